// File: rtl/bin_to_bcd_display.sv
// rtl/bin_to_bcd_display.sv - sequential double-dabble binary to packed 4-digit BCD converter
// Optional feature: define BCD_HEX_BYPASS_EN to add hex_mode (raw hex passthrough).
module bin_to_bcd_display #(
    parameter int DATA_W  = 16,
    parameter int MAX_VAL = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_value,
`ifdef BCD_HEX_BYPASS_EN
    input  logic              hex_mode,
`endif
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       display_data
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   bin_sr;
    logic [15:0]         bcd;
    logic                ovf_pending;
    logic [15:0]         bcd_adj;
    logic [15+DATA_W:0]  shifted;
    logic [15:0]         result;
    logic                result_ovf;
`ifdef BCD_HEX_BYPASS_EN
    logic                hex_pending;
    logic [15:0]         hex_value;
`endif

    // Add-3 correction on every nibble, then one left shift of {bcd, bin}.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj[14:0], bin_sr, 1'b0};
    end

    always_comb begin
        result     = ovf_pending ? 16'h9999 : bcd;
        result_ovf = ovf_pending;
`ifdef BCD_HEX_BYPASS_EN
        if (hex_pending) begin
            result     = hex_value;
            result_ovf = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            bin_sr       <= '0;
            bcd          <= '0;
            ovf_pending  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            display_data <= 16'h0000;
`ifdef BCD_HEX_BYPASS_EN
            hex_pending  <= 1'b0;
            hex_value    <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr      <= bin_value;
                        bcd         <= '0;
                        count       <= CNT_W'(DATA_W);
                        ovf_pending <= 32'(bin_value) > 32'(MAX_VAL);
                        busy        <= 1'b1;
                        state       <= SHIFT;
`ifdef BCD_HEX_BYPASS_EN
                        hex_pending <= hex_mode;
                        hex_value   <= 16'(bin_value);
`endif
                    end
                end
                SHIFT: begin
                    // All DATA_W shifts are done once count hits zero; this edge publishes.
                    if (count == '0) begin
                        display_data <= result;
                        overflow     <= result_ovf;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        bcd    <= shifted[15+DATA_W:DATA_W];
                        bin_sr <= shifted[DATA_W-1:0];
                        count  <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb/tb_bin_to_bcd_display.sv - directed self-checking bench for bin_to_bcd_display
module tb_bin_to_bcd_display;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] display_data;
`ifdef BCD_HEX_BYPASS_EN
    logic        hex_mode;
`endif

    int errors = 0;
    int checks = 0;

    bin_to_bcd_display #(.DATA_W(16), .MAX_VAL(9999)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bin_value    (bin_value),
`ifdef BCD_HEX_BYPASS_EN
        .hex_mode     (hex_mode),
`endif
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .display_data (display_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [15:0] v);
        bin_value = v;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] v,
                           input logic [15:0] exp_disp, input logic exp_ovf);
        int n;
        start_conv(v);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, n, 17);
        check({tag, "_disp"}, 32'(display_data), 32'(exp_disp));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int done_cnt;
        int done_at;

        reset     = 1'b1;
        start     = 1'b0;
        bin_value = 16'd0;
`ifdef BCD_HEX_BYPASS_EN
        hex_mode  = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_disp", 32'(display_data), 32'h0);
        reset = 1'b0;
        tick();

        convert("c1234", 16'd1234, 16'h1234, 1'b0);

        // Back-to-back: second start issued in the done cycle.
        convert("c0", 16'd0, 16'h0000, 1'b0);
        start_conv(16'd9999);
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_hold", 32'(display_data), 32'h0000);
        wait_done(n);
        check("b2b_latency", n, 17);
        check("b2b_disp", 32'(display_data), 32'h9999);
        check("b2b_ovf", 32'(overflow), 32'd0);

        convert("c10000", 16'd10000, 16'h9999, 1'b1);
        convert("c65535", 16'd65535, 16'h9999, 1'b1);
        convert("c42", 16'd42, 16'h0042, 1'b0);

        // Ignored starts and bin_value changes mid-conversion.
        start_conv(16'd5678);
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 30; i++) begin
            start     = (i == 3 || i == 9);
            if (i == 5) bin_value = 16'd1111;
            tick();
            if (i == 8) check("ign_hold", 32'(display_data), 32'h0042);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        start = 1'b0;
        check("ign_done_cnt", done_cnt, 1);
        check("ign_latency", done_at, 17);
        check("ign_disp", 32'(display_data), 32'h5678);

        // Reset mid-conversion aborts without a done pulse.
        convert("c4321", 16'd4321, 16'h4321, 1'b0);
        tick();
        start_conv(16'd8765);
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        #1;
        check("abort_disp", 32'(display_data), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        convert("c8765", 16'd8765, 16'h8765, 1'b0);

`ifdef BCD_HEX_BYPASS_EN
        hex_mode = 1'b1;
        convert("hex_beef", 16'hBEEF, 16'hBEEF, 1'b0);
        hex_mode = 1'b0;
        convert("dec_255", 16'd255, 16'h0255, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
